vme_slave_seq: RTL and testbench

//  Clocked, parametrised VME slave controller between VME bus and FPGA register file.
//  - Synchronises AS/DS strobes.
//  - Decodes board select, AM and data width, then sequences transceiver enable and FPGA read/write strobes.
//  - Generates DTACK from the FPGA acknowledge; generates BERR on illegal access or acknowledge timeout.
//  - Sits in the CPLD between the VME connector and the FPGA register file.

---
 rtl/vme_slave_seq_if.sv | 23 ++
 rtl/vme_slave_seq.sv | 184 ++++++++++++++++++
 tb/tb_vme_slave_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vme_slave_seq_if.sv
// VME slave bus bundle: VME-side strobes/address plus the FPGA register-file
// handshake. The slave modport is the controller's view.
interface vme_slave_seq_if #(
  parameter int FA_W = 5
);
  logic            AS, DS0, DS1, WRITE, IACK, LWORD;
  logic [5:0]      AM;
  logic [15:1]     A;
  logic            EQ1, EQ2, FDTACK;
  logic            DTACK, BERR, RWD, DIR, FRS, FWS;
  logic [FA_W-1:0] FA;
  logic            FD16, FHALF;

  modport slave (
    input  AS, DS0, DS1, WRITE, IACK, LWORD, AM, A, EQ1, EQ2, FDTACK,
    output DTACK, BERR, RWD, DIR, FRS, FWS, FA, FD16, FHALF
  );

  modport master (
    output AS, DS0, DS1, WRITE, IACK, LWORD, AM, A, EQ1, EQ2, FDTACK,
    input  DTACK, BERR, RWD, DIR, FRS, FWS, FA, FD16, FHALF
  );
endinterface

// File: rtl/vme_slave_seq.sv
// VME slave sequencer: synchronises the VME strobes, decodes board select,
// address modifier and data width, then drives the transceiver, the FPGA
// read/write strobes and DTACK/BERR. All bus outputs are registered.
module vme_slave_seq #(
  parameter int FA_W        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 63,
  parameter bit EN_A24      = 1'b0,
  parameter bit EN_D16      = 1'b1,
  parameter bit BERR_EN     = 1'b1
) (
  input logic            SYSCLK,
  input logic            RSTN,
  vme_slave_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ACCESS, S_ACK, S_ERROR, S_IGNORE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);

  logic [SYNC_STAGES-1:0] as_q, ds0_q, ds1_q, fdt_q;
  logic as_s, ds0_s, ds1_s, fdt_s, ds_act, ds_rel;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            arm_q, arm_d, lat;
  logic            write_q, lword_q, fhalf_q;
  logic [5:0]      am_q;
  logic [FA_W-1:0] fa_q;
  logic            sel, am_ok, w_ok;
  logic            dtack_q, berr_q, rwd_q, dir_q, frs_q, fws_q;
  logic            dtack_d, berr_d, rwd_d, dir_d, frs_d, fws_d;
  logic            unused_a;

  // Only A[FA_W+1:1] is used; the upper address bits are qualified by EQ1/EQ2.
  assign unused_a = ^bus.A;

  // Strobe synchronisers. DS stages come out of reset as "asserted" so a strobe
  // already held low when reset lifts is never seen as a fresh assertion.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      as_q  <= '1;
      ds0_q <= '0;
      ds1_q <= '0;
      fdt_q <= '1;
    end else begin
      as_q  <= {as_q[SYNC_STAGES-2:0],  bus.AS};
      ds0_q <= {ds0_q[SYNC_STAGES-2:0], bus.DS0};
      ds1_q <= {ds1_q[SYNC_STAGES-2:0], bus.DS1};
      fdt_q <= {fdt_q[SYNC_STAGES-2:0], bus.FDTACK};
    end
  end

  assign as_s   = as_q[SYNC_STAGES-1];
  assign ds0_s  = ds0_q[SYNC_STAGES-1];
  assign ds1_s  = ds1_q[SYNC_STAGES-1];
  assign fdt_s  = fdt_q[SYNC_STAGES-1];
  assign ds_act = !ds0_s && !ds1_s;
  assign ds_rel =  ds0_s &&  ds1_s;

  // Address-modifier acceptance: A32 user/supervisor data+program, optional A24.
  always_comb begin
    am_ok = 1'b0;
    case (am_q)
      6'h09, 6'h0A, 6'h0D, 6'h0E: am_ok = 1'b1;
      6'h39, 6'h3A, 6'h3D, 6'h3E: am_ok = EN_A24;
      default:                    am_ok = 1'b0;
    endcase
  end

  // Board select is taken live during DECODE; width check uses latched LWORD/A[1].
  assign sel  = bus.IACK && !bus.EQ1 && !bus.EQ2;
  assign w_ok = (!lword_q && !fhalf_q) || (EN_D16 && lword_q);

  // Next state, timeout counter, re-arm flag and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    lat     = 1'b0;
    dtack_d = 1'b1;
    berr_d  = 1'b1;
    rwd_d   = 1'b1;
    dir_d   = 1'b0;
    frs_d   = 1'b0;
    fws_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ds_rel) arm_d = 1'b1;
        // A cycle starts only after a DS release has been seen since the last one.
        if (arm_q && !as_s && ds_act) begin
          lat     = 1'b1;
          arm_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (sel && am_ok && w_ok) state_d = S_ACCESS;
        else if (sel && BERR_EN)  state_d = S_ERROR;
        else                      state_d = S_IGNORE;
      end
      S_ACCESS: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // FPGA acknowledge takes priority over a coincident timeout.
        if (!fdt_s)            state_d = S_ACK;
        else if (cnt_d == TO)  state_d = BERR_EN ? S_ERROR : S_IGNORE;
      end
      S_ACK, S_ERROR, S_IGNORE: begin
        if (ds_rel) begin
          state_d = S_IDLE;
          arm_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_ACCESS: begin
        rwd_d = 1'b0;
        dir_d = ~write_q;
        frs_d = write_q;
        fws_d = ~write_q;
      end
      S_ACK: begin
        dtack_d = 1'b0;
        rwd_d   = 1'b0;
        dir_d   = ~write_q;
      end
      S_ERROR: berr_d = 1'b0;
      default: ;
    endcase
  end

  // State, counter and bus-output registers; reset releases the bus at once.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      rwd_q   <= 1'b1;
      dir_q   <= 1'b0;
      frs_q   <= 1'b0;
      fws_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      rwd_q   <= rwd_d;
      dir_q   <= dir_d;
      frs_q   <= frs_d;
      fws_q   <= fws_d;
    end
  end

  // Address/qualifier latch, captured once at cycle start and held to the next.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      fa_q    <= '0;
      fhalf_q <= 1'b0;
      am_q    <= '0;
      write_q <= 1'b1;
      lword_q <= 1'b0;
    end else if (lat) begin
      fa_q    <= bus.A[FA_W+1:2];
      fhalf_q <= bus.A[1];
      am_q    <= bus.AM;
      write_q <= bus.WRITE;
      lword_q <= bus.LWORD;
    end
  end

  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;
  assign bus.RWD   = rwd_q;
  assign bus.DIR   = dir_q;
  assign bus.FRS   = frs_q;
  assign bus.FWS   = fws_q;
  assign bus.FA    = fa_q;
  assign bus.FD16  = lword_q;
  assign bus.FHALF = fhalf_q;
endmodule

// File: tb/tb_vme_slave_seq.sv
// Bench for vme_slave_seq: three parameterisations share one stimulus stream.
// Expected bus outputs come from an edge-arithmetic model of each VME cycle.
module tb_vme_slave_seq;
  localparam int FW_  [3] = '{5, 4, 14};
  localparam int S_   [3] = '{2, 3, 2};
  localparam int TO_  [3] = '{63, 5, 1};
  localparam bit A24_ [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit D16_ [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit BE_  [3] = '{1'b1, 1'b1, 1'b0};

  logic SYSCLK = 1'b0;
  logic RSTN   = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  vme_slave_seq_if #(.FA_W(FW_[0])) b0 ();
  vme_slave_seq_if #(.FA_W(FW_[1])) b1 ();
  vme_slave_seq_if #(.FA_W(FW_[2])) b2 ();

  vme_slave_seq #(.FA_W(FW_[0]), .SYNC_STAGES(S_[0]), .TIMEOUT(TO_[0]), .EN_A24(A24_[0]),
                  .EN_D16(D16_[0]), .BERR_EN(BE_[0])) dut0 (.SYSCLK(SYSCLK), .RSTN(RSTN), .bus(b0));
  vme_slave_seq #(.FA_W(FW_[1]), .SYNC_STAGES(S_[1]), .TIMEOUT(TO_[1]), .EN_A24(A24_[1]),
                  .EN_D16(D16_[1]), .BERR_EN(BE_[1])) dut1 (.SYSCLK(SYSCLK), .RSTN(RSTN), .bus(b1));
  vme_slave_seq #(.FA_W(FW_[2]), .SYNC_STAGES(S_[2]), .TIMEOUT(TO_[2]), .EN_A24(A24_[2]),
                  .EN_D16(D16_[2]), .BERR_EN(BE_[2])) dut2 (.SYSCLK(SYSCLK), .RSTN(RSTN), .bus(b2));

  // b0 is driven by the bench; the other two buses mirror its inputs.
  assign b1.AS = b0.AS;       assign b2.AS = b0.AS;
  assign b1.DS0 = b0.DS0;     assign b2.DS0 = b0.DS0;
  assign b1.DS1 = b0.DS1;     assign b2.DS1 = b0.DS1;
  assign b1.WRITE = b0.WRITE; assign b2.WRITE = b0.WRITE;
  assign b1.IACK = b0.IACK;   assign b2.IACK = b0.IACK;
  assign b1.LWORD = b0.LWORD; assign b2.LWORD = b0.LWORD;
  assign b1.AM = b0.AM;       assign b2.AM = b0.AM;
  assign b1.A = b0.A;         assign b2.A = b0.A;
  assign b1.EQ1 = b0.EQ1;     assign b2.EQ1 = b0.EQ1;
  assign b1.EQ2 = b0.EQ2;     assign b2.EQ2 = b0.EQ2;
  assign b1.FDTACK = b0.FDTACK; assign b2.FDTACK = b0.FDTACK;

  // {DTACK, BERR, RWD, DIR, FRS, FWS}
  logic [5:0]  obs    [3];
  logic [15:0] fa_obs [3];
  logic [1:0]  fx_obs [3];
  assign obs[0] = {b0.DTACK, b0.BERR, b0.RWD, b0.DIR, b0.FRS, b0.FWS};
  assign obs[1] = {b1.DTACK, b1.BERR, b1.RWD, b1.DIR, b1.FRS, b1.FWS};
  assign obs[2] = {b2.DTACK, b2.BERR, b2.RWD, b2.DIR, b2.FRS, b2.FWS};
  assign fa_obs[0] = 16'(b0.FA);
  assign fa_obs[1] = 16'(b1.FA);
  assign fa_obs[2] = 16'(b2.FA);
  assign fx_obs[0] = {b0.FD16, b0.FHALF};
  assign fx_obs[1] = {b1.FD16, b1.FHALF};
  assign fx_obs[2] = {b2.FD16, b2.FHALF};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int n, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s n=%0d got=%h want=%h", tag, n, o, e);
    end
  endtask

  // Cycle outcome from the decode rules: 1 error, 2 ignore, 3 access.
  function automatic int decode(int d, logic iack, logic eq1, logic eq2, logic [5:0] am,
                                logic lw, logic a1);
    bit sel, amok, wok;
    sel  = iack && !eq1 && !eq2;
    amok = (am inside {6'h09, 6'h0A, 6'h0D, 6'h0E}) ||
           (A24_[d] && (am inside {6'h39, 6'h3A, 6'h3D, 6'h3E}));
    wok  = (!lw && !a1) || (D16_[d] && lw);
    if (!sel) return 2;
    if (amok && wok) return 3;
    return BE_[d] ? 1 : 2;
  endfunction

  // Bus outputs per phase: 0 ack, 1 error, 2 idle/ignore, 3 access.
  function automatic logic [5:0] exp_vec(int st, logic wr);
    case (st)
      3:       return {1'b1, 1'b1, 1'b0, ~wr, wr, ~wr};
      0:       return {1'b0, 1'b1, 1'b0, ~wr, 1'b0, 1'b0};
      1:       return 6'b101000;
      default: return 6'b111000;
    endcase
  endfunction

  // One VME cycle. Strobes drop right after edge 0; FDTACK drops after edge k
  // (k<0: never); DS released after edge r. Outputs are checked every cycle.
  task automatic run_cyc(input string tag, input logic wr, input logic lw, input logic [5:0] am,
                         input logic [15:0] addr, input logic iack, input logic eq1,
                         input logic eq2, input int k);
    int post [3];
    int e_end [3];
    int r, as_rel, ack_e, st;
    logic [15:0] fa_exp;
    for (int d = 0; d < 3; d++) begin
      st = decode(d, iack, eq1, eq2, am, lw, addr[1]);
      if (st == 3) begin
        ack_e = (k < 0) ? 100000 : ((k + S_[d] + 1 > S_[d] + 3) ? k + S_[d] + 1 : S_[d] + 3);
        if (ack_e <= S_[d] + 2 + TO_[d]) begin
          e_end[d] = ack_e;
          post[d]  = 0;
        end else begin
          e_end[d] = S_[d] + 2 + TO_[d];
          post[d]  = BE_[d] ? 1 : 2;
        end
      end else begin
        e_end[d] = S_[d] + 2;
        post[d]  = st;
      end
    end
    r = 0;
    for (int d = 0; d < 3; d++) if (e_end[d] > r) r = e_end[d];
    r = r + int'($urandom_range(1, 3));
    as_rel = int'($urandom_range(5, r));
    b0.WRITE = wr; b0.LWORD = lw; b0.AM = am; b0.A = addr[15:1];
    b0.IACK = iack; b0.EQ1 = eq1; b0.EQ2 = eq2;
    b0.AS = 1'b0; b0.DS0 = 1'b0; b0.DS1 = 1'b0;
    b0.FDTACK = (k == 0) ? 1'b0 : 1'b1;
    for (int n = 1; n <= r + 6; n++) begin
      @(posedge SYSCLK); #1;
      if (n == k && n < r) b0.FDTACK = 1'b0;
      if (n == as_rel) b0.AS = 1'b1;
      if (n == r) begin
        b0.DS0 = 1'b1; b0.DS1 = 1'b1; b0.AS = 1'b1; b0.FDTACK = 1'b1;
      end
      @(negedge SYSCLK);
      for (int d = 0; d < 3; d++) begin
        st = (n < S_[d] + 2 || n >= r + S_[d] + 1) ? 2 : ((n < e_end[d]) ? 3 : post[d]);
        chk($sformatf("%s.bus%0d", tag, d), n, 16'(obs[d]), 16'(exp_vec(st, wr)));
        if (n == r) begin
          fa_exp = (addr >> 2) & 16'((1 << FW_[d]) - 1);
          chk($sformatf("%s.fa%0d", tag, d), n, fa_obs[d], fa_exp);
          chk($sformatf("%s.fx%0d", tag, d), n, 16'(fx_obs[d]), 16'({lw, addr[1]}));
        end
      end
    end
  endtask

  initial begin
    logic [5:0] am_tab [9];
    logic [5:0] am_r;
    int kr;
    am_tab = '{6'h09, 6'h0A, 6'h0D, 6'h0E, 6'h39, 6'h3A, 6'h3D, 6'h3E, 6'h29};
    b0.AS = 1'b1; b0.DS0 = 1'b1; b0.DS1 = 1'b1; b0.FDTACK = 1'b1;
    b0.WRITE = 1'b1; b0.IACK = 1'b1; b0.LWORD = 1'b1; b0.AM = '0; b0.A = '0;
    b0.EQ1 = 1'b1; b0.EQ2 = 1'b1;

    // reset values
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst.bus%0d", d), 0, 16'(obs[d]), 16'(6'b111000));
      chk($sformatf("rst.fa%0d", d), 0, fa_obs[d], 16'h0);
      chk($sformatf("rst.fx%0d", d), 0, 16'(fx_obs[d]), 16'h0);
    end
    @(posedge SYSCLK); #1 RSTN = 1'b1;
    repeat (8) @(posedge SYSCLK);
    #1;

    // directed cycles
    run_cyc("t1_wr32",   1'b0, 1'b0, 6'h09, 16'h0014, 1'b1, 1'b0, 1'b0, 4);
    run_cyc("t2_rd32",   1'b1, 1'b0, 6'h0D, 16'h007C, 1'b1, 1'b0, 1'b0, 3);
    run_cyc("t3_badam",  1'b1, 1'b0, 6'h29, 16'h0010, 1'b1, 1'b0, 1'b0, -1);
    run_cyc("t3_nosel",  1'b1, 1'b0, 6'h29, 16'h0010, 1'b1, 1'b1, 1'b0, -1);
    run_cyc("t4_tmo",    1'b1, 1'b0, 6'h09, 16'h0020, 1'b1, 1'b0, 1'b0, -1);
    run_cyc("t4_tmoack", 1'b1, 1'b0, 6'h09, 16'h0024, 1'b1, 1'b0, 1'b0, 64);
    run_cyc("t5_d16",    1'b1, 1'b1, 6'h09, 16'h0002, 1'b1, 1'b0, 1'b0, 2);
    run_cyc("t5_d32odd", 1'b0, 1'b0, 6'h0A, 16'h0006, 1'b1, 1'b0, 1'b0, 1);
    run_cyc("t7_a24",    1'b0, 1'b0, 6'h39, 16'h0008, 1'b1, 1'b0, 1'b0, 0);
    run_cyc("t8_iack",   1'b1, 1'b0, 6'h09, 16'h0008, 1'b0, 1'b0, 1'b0, 0);

    // reset in the middle of ACK, then held DS must not start a cycle
    b0.WRITE = 1'b0; b0.LWORD = 1'b0; b0.AM = 6'h09; b0.A = 15'h000A;
    b0.IACK = 1'b1; b0.EQ1 = 1'b0; b0.EQ2 = 1'b0;
    b0.AS = 1'b0; b0.DS0 = 1'b0; b0.DS1 = 1'b0; b0.FDTACK = 1'b0;
    repeat (10) @(posedge SYSCLK);
    @(negedge SYSCLK);
    for (int d = 0; d < 3; d++)
      chk($sformatf("t6_ack.bus%0d", d), 10, 16'(obs[d]), 16'(6'b010100));
    #2 RSTN = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t6_rst.bus%0d", d), 10, 16'(obs[d]), 16'(6'b111000));
      chk($sformatf("t6_rst.fa%0d", d), 10, fa_obs[d], 16'h0);
    end
    repeat (2) @(posedge SYSCLK);
    #1 RSTN = 1'b1; b0.FDTACK = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge SYSCLK);
      for (int d = 0; d < 3; d++)
        chk($sformatf("t6_held.bus%0d", d), n, 16'(obs[d]), 16'(6'b111000));
    end
    @(posedge SYSCLK); #1;
    b0.AS = 1'b1; b0.DS0 = 1'b1; b0.DS1 = 1'b1;
    repeat (8) @(posedge SYSCLK);
    #1;
    run_cyc("t6_again", 1'b1, 1'b0, 6'h0E, 16'h0030, 1'b1, 1'b0, 1'b0, 2);

    // randomized cycles
    for (int i = 0; i < 40; i++) begin
      am_r = ($urandom_range(0, 9) == 9) ? 6'($urandom) : am_tab[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0:       kr = -1;
        1:       kr = int'($urandom_range(0, 8));
        2:       kr = int'($urandom_range(60, 66));
        default: kr = int'($urandom_range(0, 30));
      endcase
      run_cyc($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), am_r, 16'($urandom),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), kr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
